// File: rtl/fifo_wm_top.sv
// fifo_wm_top: synchronous FIFO with programmable almost-full/almost-empty watermarks and sticky ovf/udf flags.
// Define FIFO_WM_FWFT_EN for first-word-fall-through reads; otherwise data_out is registered on pop.
module fifo_wm_top #(
  parameter int FIFO_SIZE = 64,
  parameter int W_WIDTH = 32,
  localparam int CNT_W = $clog2(FIFO_SIZE) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fifo_en,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [W_WIDTH-1:0] data_in,
  input  logic [CNT_W-1:0]   afull_thr,
  input  logic [CNT_W-1:0]   aempty_thr,
  input  logic               clr_err,
  output logic [W_WIDTH-1:0] data_out,
  output logic               full,
  output logic               empty,
  output logic               afull,
  output logic               aempty,
  output logic               last,
  output logic [CNT_W-1:0]   count,
  output logic               ovf,
  output logic               udf
);
  localparam int PW = $clog2(FIFO_SIZE);
  logic [W_WIDTH-1:0] mem [FIFO_SIZE];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic pop_ok, push_ok, ovf_set, udf_set;
  assign empty = cnt == '0;
  assign full = cnt == CNT_W'(FIFO_SIZE);
  assign last = cnt == CNT_W'(1);
  assign afull = cnt >= afull_thr;
  assign aempty = cnt <= aempty_thr;
  assign count = cnt;
  // a pop frees a slot in the same cycle, so push-while-full is legal alongside it
  assign pop_ok = fifo_en && rd_en && !empty;
  assign push_ok = fifo_en && wr_en && (!full || pop_ok);
  assign ovf_set = fifo_en && wr_en && full && !pop_ok;
  assign udf_set = fifo_en && rd_en && empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (fifo_en) begin
      wr_ptr <= wr_ptr + PW'(push_ok);
      rd_ptr <= rd_ptr + PW'(pop_ok);
      cnt <= cnt + CNT_W'(push_ok) - CNT_W'(pop_ok);
      ovf <= ovf_set | (ovf & ~clr_err);
      udf <= udf_set | (udf & ~clr_err);
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem[wr_ptr] <= data_in;
  end
`ifdef FIFO_WM_FWFT_EN
  assign data_out = empty ? '0 : mem[rd_ptr];
`else
  always_ff @(posedge clk) begin
    if (rst) data_out <= '0;
    else if (pop_ok) data_out <= mem[rd_ptr];
  end
`endif
endmodule

// File: doc/fifo_wm_top.md
FIFO_WM_TOP -- requirements
Module: fifo_wm_top

Interface
REQ-001 SHALL have parameter FIFO_SIZE, default 64, depth in words; power of two, at least 4.
REQ-002 SHALL have parameter W_WIDTH, default 32, data word width in bits.
REQ-003 SHALL derive local parameter CNT_W = $clog2(FIFO_SIZE)+1, the occupancy and threshold width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port fifo_en  input  1  global enable; when 0, no push, no pop, no error update.
REQ-007 SHALL have port wr_en  input  1  push request.
REQ-008 SHALL have port rd_en  input  1  pop request.
REQ-009 SHALL have port data_in  input  W_WIDTH  push data.
REQ-010 SHALL have port afull_thr  input  CNT_W  almost-full threshold.
REQ-011 SHALL have port aempty_thr  input  CNT_W  almost-empty threshold.
REQ-012 SHALL have port clr_err  input  1  clears the sticky error flags.
REQ-013 SHALL have port data_out  output  W_WIDTH  pop data.
REQ-014 SHALL have ports full, empty, afull, aempty, last  output  1 each  status flags.
REQ-015 SHALL have port count  output  CNT_W  current occupancy, 0..FIFO_SIZE.
REQ-016 SHALL have ports ovf, udf  output  1 each  sticky overflow and underflow flags.

Function
REQ-017 SHALL accept a push when fifo_en && wr_en && (!full || pop accepted in the same cycle).
REQ-018 SHALL accept a pop when fifo_en && rd_en && !empty.
REQ-019 SHALL handle a simultaneous accepted push and pop as follows: count unchanged; both pointers advance; legal when full.
REQ-020 SHALL, on push and pop together while empty, accept the push only, set udf, and make count 1.
REQ-021 SHALL wrap read and write pointers modulo FIFO_SIZE; pointer width SHALL be $clog2(FIFO_SIZE).
REQ-022 SHALL register count; it increments on a push-only cycle and decrements on a pop-only cycle.
REQ-023 SHALL decode status from the registered count: empty = (count==0), full = (count==FIFO_SIZE), last = (count==1), afull = (count>=afull_thr), aempty = (count<=aempty_thr).
REQ-024 SHALL set ovf on fifo_en && wr_en && full && no accepted pop; the push SHALL be discarded and memory left unchanged.
REQ-025 SHALL set udf on fifo_en && rd_en && empty; data_out SHALL hold its value.
REQ-026 SHALL clear ovf and udf one cycle after clr_err=1; a new error in the same cycle as clr_err SHALL win, leaving the flag set.
REQ-027 SHALL, with fifo_en=0, hold all state and outputs except threshold-driven afull and aempty, which follow afull_thr and aempty_thr.
REQ-028 SHALL treat a threshold change as taking effect in the same cycle (combinational compare).

Reset
REQ-029 SHALL, on rst=1 at a clock edge, clear pointers, count, data_out, ovf and udf to 0; memory contents are not reset.
REQ-030 SHALL produce these outputs after reset: empty=1, full=0, last=0, aempty=1, and afull=1 only if afull_thr==0.
REQ-031 SHALL give reset priority over every push, pop and clr_err in the same cycle, including reset mid-burst.

Configuration
REQ-032 SHALL use macro FIFO_WM_FWFT_EN to select the read mode.
REQ-033 SHALL, with FIFO_WM_FWFT_EN defined, run first-word-fall-through: data_out = mem[rd_ptr] combinationally while !empty, 0 while empty, and an accepted pop advances to the next word in the same cycle.
REQ-034 SHALL, with FIFO_WM_FWFT_EN undefined, register data_out: it shows the popped word one cycle after the accepted pop and holds between pops.

Verification
REQ-035 SHALL cover reset then push 0xA5A5_0001..0xA5A5_0004 with FIFO_SIZE=64 -> count=4, last=0, and pops return data in order (registered mode: 1-cycle latency).
REQ-036 SHALL cover filling to 64 then one extra push -> full=1, ovf=1, count=64, and the extra word never read.
REQ-037 SHALL cover push and pop together when full, data 0x1234 -> count stays 64, no ovf, and 0x1234 is read 64 pops later.
REQ-038 SHALL cover a pop on empty, then clr_err -> udf=1 next cycle, data_out unchanged, and udf=0 the cycle after clr_err.
REQ-039 SHALL cover afull_thr=60, aempty_thr=2, filling 0->64 -> aempty=1 for count<=2, last=1 only at count 1, afull=1 from count 60.
REQ-040 SHALL cover rst asserted at count=10 during a push/pop burst -> next cycle count=0, empty=1, ovf=udf=0, data_out=0.
